// File: rtl/pulp_clock_gate_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulp_clock_gate_ctrl_if: control/handshake bundle for the clock-gate ctrl, rev 1.0
// ----------------------------------------------------------------------------
interface pulp_clock_gate_ctrl_if #(
  parameter int IDLE_CNT_WIDTH = 8
);
  logic                      busy_i;
  logic                      wake_i;
  logic                      force_en_i;
  logic [IDLE_CNT_WIDTH-1:0] idle_thresh_i;
  logic                      quiesce_req_o;
  logic                      quiesce_ack_i;
  logic                      clk_en_o;
  logic                      ready_o;
  logic                      gated_o;

  modport master (
    input  busy_i, wake_i, force_en_i, idle_thresh_i, quiesce_ack_i,
    output quiesce_req_o, clk_en_o, ready_o, gated_o
  );

  modport slave (
    output busy_i, wake_i, force_en_i, idle_thresh_i, quiesce_ack_i,
    input  quiesce_req_o, clk_en_o, ready_o, gated_o
  );
endinterface
`default_nettype wire

// File: rtl/pulp_clock_gate_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pulp_clock_gate_ctrl: idle-driven clock-gate enable with quiesce handshake, rev 1.0
// ----------------------------------------------------------------------------
module pulp_clock_gate_ctrl #(
  parameter int IDLE_CNT_WIDTH = 8,
  parameter int WAKE_CYCLES    = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  pulp_clock_gate_ctrl_if.master bus
);

  localparam int WAKE_CNT_WIDTH = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [WAKE_CNT_WIDTH-1:0] WAKE_LOAD = WAKE_CNT_WIDTH'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    GATED  = 2'd2,
    WAKE   = 2'd3
  } state_t;

  state_t                    state, next_state;
  logic [IDLE_CNT_WIDTH-1:0] idle_cnt, next_idle_cnt;
  logic [WAKE_CNT_WIDTH-1:0] wake_cnt, next_wake_cnt;
  logic                      idle;
  logic                      abort;
  logic                      clk_en, ready, quiesce_req, gated;
  logic                      next_clk_en, next_ready, next_quiesce_req, next_gated;

  assign idle  = !bus.busy_i && !bus.wake_i && !bus.force_en_i &&
                 (bus.idle_thresh_i != '0);
  assign abort = bus.busy_i | bus.wake_i | bus.force_en_i;

  always_comb begin
    next_state    = state;
    next_idle_cnt = idle_cnt;
    next_wake_cnt = wake_cnt;
    case (state)
      ACTIVE: begin
        // >= lets a lowered threshold fire on the very next idle cycle
        if (idle) begin
          if (idle_cnt >= (bus.idle_thresh_i - IDLE_CNT_WIDTH'(1))) begin
            next_state    = DRAIN;
            next_idle_cnt = '0;
          end else begin
            next_idle_cnt = idle_cnt + IDLE_CNT_WIDTH'(1);
          end
        end else begin
          next_idle_cnt = '0;
        end
      end
      DRAIN: begin
        if (abort) begin
          next_state = ACTIVE;
        end else if (bus.quiesce_ack_i) begin
          next_state = GATED;
        end
      end
      GATED: begin
        if (bus.wake_i || bus.force_en_i) begin
          next_state    = WAKE;
          next_wake_cnt = WAKE_LOAD;
        end
      end
      WAKE: begin
        if (wake_cnt == '0) begin
          next_state = ACTIVE;
        end else begin
          next_wake_cnt = wake_cnt - WAKE_CNT_WIDTH'(1);
        end
      end
      default: begin
        next_state = ACTIVE;
      end
    endcase

    // Outputs are decoded from the next state so each is a plain flop.
    next_clk_en      = (next_state != GATED);
    next_ready       = (next_state == ACTIVE) || (next_state == DRAIN);
    next_quiesce_req = (next_state == DRAIN);
    next_gated       = (next_state == GATED);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= WAKE;
      idle_cnt    <= '0;
      wake_cnt    <= WAKE_LOAD;
      clk_en      <= 1'b1;
      ready       <= 1'b0;
      quiesce_req <= 1'b0;
      gated       <= 1'b0;
    end else begin
      state       <= next_state;
      idle_cnt    <= next_idle_cnt;
      wake_cnt    <= next_wake_cnt;
      clk_en      <= next_clk_en;
      ready       <= next_ready;
      quiesce_req <= next_quiesce_req;
      gated       <= next_gated;
    end
  end

  assign bus.clk_en_o      = clk_en;
  assign bus.ready_o       = ready;
  assign bus.quiesce_req_o = quiesce_req;
  assign bus.gated_o       = gated;

endmodule
`default_nettype wire

// File: tb/tb_pulp_clock_gate_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pulp_clock_gate_ctrl: directed + random bench against a behavioural model, rev 1.0
// ----------------------------------------------------------------------------
module tb_pulp_clock_gate_ctrl;

  localparam int IDLE_CNT_WIDTH = 8;
  localparam int WAKE_CYCLES    = 2;

  logic clk;
  logic rst;

  pulp_clock_gate_ctrl_if #(.IDLE_CNT_WIDTH(IDLE_CNT_WIDTH)) bus ();

  pulp_clock_gate_ctrl #(
    .IDLE_CNT_WIDTH(IDLE_CNT_WIDTH),
    .WAKE_CYCLES   (WAKE_CYCLES)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fails;

  // Model: wake_left counts edges still to go before the domain is usable.
  int wake_left;
  int idle_run;
  bit m_gated;
  bit m_drain;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    wake_left = WAKE_CYCLES;
    idle_run  = 0;
    m_gated   = 1'b0;
    m_drain   = 1'b0;
  endtask

  task automatic model_edge();
    if (m_gated) begin
      if (bus.wake_i || bus.force_en_i) begin
        m_gated   = 1'b0;
        wake_left = WAKE_CYCLES;
      end
    end else if (wake_left > 0) begin
      wake_left--;
    end else if (m_drain) begin
      if (bus.busy_i || bus.wake_i || bus.force_en_i) begin
        m_drain = 1'b0;
      end else if (bus.quiesce_ack_i) begin
        m_drain = 1'b0;
        m_gated = 1'b1;
      end
    end else begin
      if (!bus.busy_i && !bus.wake_i && !bus.force_en_i && bus.idle_thresh_i != 0)
        idle_run++;
      else
        idle_run = 0;
      if (idle_run != 0 && idle_run >= int'(bus.idle_thresh_i)) begin
        m_drain  = 1'b1;
        idle_run = 0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".clk_en"}, bus.clk_en_o, !m_gated);
    check_eq({tag, ".ready"}, bus.ready_o, !m_gated && wake_left == 0);
    check_eq({tag, ".req"}, bus.quiesce_req_o, m_drain);
    check_eq({tag, ".gated"}, bus.gated_o, m_gated);
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic edges_until_req(input string tag, output int n);
    n = -1;
    for (int i = 1; i <= 50; i++) begin
      cycle(tag);
      if (bus.quiesce_req_o === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Reset is raised mid-low-phase; outputs must respond with no clock edge.
  task automatic async_reset_check(input string tag);
    #2 rst = 1'b1;
    #1;
    check_eq({tag, ".clk_en"}, bus.clk_en_o, 1'b1);
    check_eq({tag, ".req"}, bus.quiesce_req_o, 1'b0);
    check_eq({tag, ".ready"}, bus.ready_o, 1'b0);
    check_eq({tag, ".gated"}, bus.gated_o, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.busy_i        = 1'b0;
    bus.wake_i        = 1'b0;
    bus.force_en_i    = 1'b0;
    bus.quiesce_ack_i = 1'b0;
  endtask

  initial begin
    int n;
    int thr_tab[7];
    n_checks = 0;
    n_fails  = 0;
    thr_tab  = '{0, 1, 2, 3, 4, 5, 8};

    rst = 1'b1;
    idle_inputs();
    bus.idle_thresh_i = '0;
    model_reset();
    #1;
    check_eq("rst.clk_en", bus.clk_en_o, 1'b1);
    check_eq("rst.ready", bus.ready_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Threshold 0: wake sequence then ACTIVE forever
    cycle("wake0");
    check_eq("wake0.ready_e1", bus.ready_o, 1'b0);
    cycle("wake0");
    check_eq("wake0.ready_e2", bus.ready_o, 1'b1);
    for (int i = 0; i < 10; i++) cycle("thr0");
    check_eq("thr0.req", bus.quiesce_req_o, 1'b0);

    // Threshold 4: request on the 4th idle edge, gated on the ack edge
    bus.idle_thresh_i = 8'd4;
    edges_until_req("gate4", n);
    check_eq("gate4.req_edge", n, 4);
    bus.quiesce_ack_i = 1'b1;
    cycle("gate4");
    bus.quiesce_ack_i = 1'b0;
    check_eq("gate4.gated", bus.gated_o, 1'b1);
    check_eq("gate4.clk_en", bus.clk_en_o, 1'b0);

    // One-cycle wake pulse
    bus.wake_i = 1'b1;
    cycle("wake");
    bus.wake_i = 1'b0;
    check_eq("wake.clk_en", bus.clk_en_o, 1'b1);
    cycle("wake");
    cycle("wake");
    check_eq("wake.ready", bus.ready_o, 1'b1);
    edges_until_req("regate", n);
    check_eq("regate.req_edge", n, 4);

    // Abort beats ack in DRAIN
    bus.busy_i        = 1'b1;
    bus.quiesce_ack_i = 1'b1;
    cycle("abort");
    check_eq("abort.req", bus.quiesce_req_o, 1'b0);
    check_eq("abort.clk_en", bus.clk_en_o, 1'b1);
    idle_inputs();

    // Busy pulse on idle cycle 3 restarts the count
    cycle("bpulse");
    cycle("bpulse");
    check_eq("bpulse.noreq", bus.quiesce_req_o, 1'b0);
    bus.busy_i = 1'b1;
    cycle("bpulse");
    bus.busy_i = 1'b0;
    edges_until_req("bpulse", n);
    check_eq("bpulse.req_edge", n, 4);

    // Reset mid-DRAIN, then mid-GATED
    async_reset_check("rst_drain");
    cycle("rst_drain");
    cycle("rst_drain");
    check_eq("rst_drain.ready", bus.ready_o, 1'b1);
    edges_until_req("rst_gated", n);
    bus.quiesce_ack_i = 1'b1;
    cycle("rst_gated");
    bus.quiesce_ack_i = 1'b0;
    check_eq("rst_gated.gated", bus.gated_o, 1'b1);
    async_reset_check("rst_gated");
    cycle("rst_gated");
    cycle("rst_gated");
    check_eq("rst_gated.ready", bus.ready_o, 1'b1);

    // Random traffic biased towards idle so gating happens often
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset_check("rnd_rst");
      end else begin
        if ($urandom_range(0, 63) == 0)
          bus.idle_thresh_i = IDLE_CNT_WIDTH'(thr_tab[$urandom_range(0, 6)]);
        bus.busy_i        = ($urandom_range(0, 7) == 0);
        bus.wake_i        = ($urandom_range(0, 23) == 0);
        bus.force_en_i    = ($urandom_range(0, 39) == 0);
        bus.quiesce_ack_i = ($urandom_range(0, 1) == 0);
        cycle("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
